// File: rtl/c3_simd_pkg.sv
// Shared constants for the C3 SIMD ALU: mode encodings, lane-width legality, flag placement.
package c3_simd_pkg;

    localparam logic [2:0] C3_ADD    = 3'd0;
    localparam logic [2:0] C3_SUB    = 3'd1;
    localparam logic [2:0] C3_SADDS  = 3'd2;
    localparam logic [2:0] C3_MINS   = 3'd3;
    localparam logic [2:0] C3_MAXS   = 3'd4;
    localparam logic [2:0] C3_REDSUM = 3'd5;
    localparam logic [2:0] C3_ACC    = 3'd6;
    localparam logic [2:0] C3_ACCCLR = 3'd7;

    // Bit position of the per-lane flag inside each out_vdata2 lane.
    localparam int unsigned FLAG_BIT = 0;

    // Supported lane widths are 8, 16 and 32 bits.
    function automatic bit lane_w_legal(input int unsigned w);
        return (w == 8) || (w == 16) || (w == 32);
    endfunction

endpackage

// File: rtl/c3_simd_lane.sv
// One SIMD lane: combinational mode mux, signed saturation, flag and accumulator next value.
module c3_simd_lane
    import c3_simd_pkg::*;
#(
    parameter int unsigned LANE_W = 32
) (
    input  logic [2:0]        mode_i,
    input  logic [LANE_W-1:0] a_i,
    input  logic [LANE_W-1:0] b_i,
    input  logic [LANE_W-1:0] acc_i,
    input  logic [4:0]        shamt_i,
    output logic [LANE_W-1:0] r_o,
    output logic              flag_o,
    output logic [LANE_W-1:0] acc_d_o
);

    localparam logic [LANE_W-1:0] SatMax = {1'b0, {(LANE_W-1){1'b1}}};
    localparam logic [LANE_W-1:0] SatMin = {1'b1, {(LANE_W-1){1'b0}}};

    logic [LANE_W:0]     sum;
    logic [LANE_W:0]     diff;
    logic [LANE_W:0]     acc_sum;
    logic [LANE_W-1:0]   sat_sum;
    logic [LANE_W-1:0]   addend;
    logic [2*LANE_W-1:0] prod;
    logic                sadd_ovf;
    logic                a_lt_b;
    logic                a_gt_b;

    // Lane arithmetic and result/flag selection by mode.
    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = {1'b0, a_i} - {1'b0, b_i};
        // Signed overflow: operands agree in sign, result does not.
        sadd_ovf = (a_i[LANE_W-1] == b_i[LANE_W-1]) && (sum[LANE_W-1] != a_i[LANE_W-1]);
        sat_sum  = sadd_ovf ? (a_i[LANE_W-1] ? SatMin : SatMax) : sum[LANE_W-1:0];
        a_lt_b   = $signed(a_i) < $signed(b_i);
        a_gt_b   = $signed(a_i) > $signed(b_i);
        prod     = {{LANE_W{1'b0}}, a_i} * {{LANE_W{1'b0}}, b_i};
        addend   = LANE_W'(prod >> shamt_i);
        acc_sum  = {1'b0, acc_i} + {1'b0, addend};

        r_o      = '0;
        flag_o   = 1'b0;
        acc_d_o  = acc_i;
        case (mode_i)
            C3_ADD: begin
                r_o    = sum[LANE_W-1:0];
                flag_o = sum[LANE_W];
            end
            C3_SUB: begin
                r_o    = diff[LANE_W-1:0];
                flag_o = diff[LANE_W];
            end
            C3_SADDS: begin
                r_o    = sat_sum;
                flag_o = sadd_ovf;
            end
            C3_MINS: begin
                r_o    = a_lt_b ? a_i : b_i;
                flag_o = a_lt_b;
            end
            C3_MAXS: begin
                r_o    = a_gt_b ? a_i : b_i;
                flag_o = a_gt_b;
            end
            C3_ACC: begin
                r_o     = acc_sum[LANE_W-1:0];
                flag_o  = acc_sum[LANE_W];
                acc_d_o = acc_sum[LANE_W-1:0];
            end
            C3_ACCCLR: begin
                r_o     = acc_i;
                acc_d_o = '0;
            end
            default: begin
                // REDSUM: lane outputs stay zero, reduction lives in the top.
                r_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/c3_simd_alu_pipe.sv
// Pipelined multi-mode SIMD ALU for the C3 custom slot: lanes, accumulator, reduction, delay line.
module c3_simd_alu_pipe
    import c3_simd_pkg::*;
#(
    parameter int unsigned VLEN        = 256,
    parameter int unsigned LANE_W      = 32,
    parameter int unsigned PIPE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_v,
    input  logic [2:0]      in_mode,
    input  logic [4:0]      rd,
    input  logic [2:0]      vrd1,
    input  logic [2:0]      vrd2,
    input  logic [31:0]     in_data,
    input  logic [VLEN-1:0] in_vdata1,
    input  logic [VLEN-1:0] in_vdata2,
    output logic            out_v,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_vrd1,
    output logic [2:0]      out_vrd2,
    output logic [31:0]     out_data,
    output logic [VLEN-1:0] out_vdata1,
    output logic [VLEN-1:0] out_vdata2
);

    localparam int unsigned NL       = VLEN / LANE_W;
    localparam int unsigned TreeLvls = $clog2(NL);
    localparam int unsigned TreeW    = 1 << TreeLvls;

    if (!lane_w_legal(LANE_W) || (VLEN % 32 != 0) || (PIPE_CYCLES < 1)) begin : g_param_err
        $error("c3_simd_alu_pipe: illegal VLEN/LANE_W/PIPE_CYCLES");
    end

    // Balanced adder tree over zero-extended lanes, padded to a power of two.
    function automatic logic [31:0] red_sum(input logic [VLEN-1:0] v);
        logic [31:0] node [TreeW];
        for (int i = 0; i < TreeW; i++) begin
            if (i < NL) node[i] = 32'(v[i*LANE_W +: LANE_W]);
            else        node[i] = '0;
        end
        for (int w = TreeW / 2; w >= 1; w = w / 2) begin
            for (int k = 0; k < w; k++) node[k] = node[2*k] + node[2*k+1];
        end
        return node[0];
    endfunction

    logic [VLEN-1:0] acc_q, acc_d, acc_lane_d;
    logic [VLEN-1:0] s1_vd1, s1_vd2;
    logic [31:0]     s1_data;
    logic            acc_we;

    logic [PIPE_CYCLES-1:0] v_q, v_d;
    logic [4:0]      rd_q   [PIPE_CYCLES];
    logic [4:0]      rd_d   [PIPE_CYCLES];
    logic [2:0]      vrd1_q [PIPE_CYCLES];
    logic [2:0]      vrd1_d [PIPE_CYCLES];
    logic [2:0]      vrd2_q [PIPE_CYCLES];
    logic [2:0]      vrd2_d [PIPE_CYCLES];
    logic [31:0]     data_q [PIPE_CYCLES];
    logic [31:0]     data_d [PIPE_CYCLES];
    logic [VLEN-1:0] vd1_q  [PIPE_CYCLES];
    logic [VLEN-1:0] vd1_d  [PIPE_CYCLES];
    logic [VLEN-1:0] vd2_q  [PIPE_CYCLES];
    logic [VLEN-1:0] vd2_d  [PIPE_CYCLES];

    // Only the shift amount of the scalar operand is consumed.
    logic unused_in_data;
    assign unused_in_data = ^in_data[31:5];

    for (genvar i = 0; i < NL; i++) begin : g_lane
        logic lane_flag;
        c3_simd_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .mode_i  (in_mode),
            .a_i     (in_vdata1[i*LANE_W +: LANE_W]),
            .b_i     (in_vdata2[i*LANE_W +: LANE_W]),
            .acc_i   (acc_q[i*LANE_W +: LANE_W]),
            .shamt_i (in_data[4:0]),
            .r_o     (s1_vd1[i*LANE_W +: LANE_W]),
            .flag_o  (lane_flag),
            .acc_d_o (acc_lane_d[i*LANE_W +: LANE_W])
        );
        assign s1_vd2[i*LANE_W +: LANE_W] = LANE_W'(lane_flag) << FLAG_BIT;
    end

    // Stage-1 scalar result and accumulator next state.
    always_comb begin
        s1_data = (in_mode == C3_REDSUM) ? red_sum(in_vdata1) : '0;
        acc_we  = in_v && ((in_mode == C3_ACC) || (in_mode == C3_ACCCLR));
        acc_d   = acc_we ? acc_lane_d : acc_q;
    end

    // Delay line: stage 0 captures stage-1 results, later stages copy forward on valid.
    always_comb begin
        v_d[0]    = in_v;
        rd_d[0]   = in_v ? rd        : rd_q[0];
        vrd1_d[0] = in_v ? vrd1      : vrd1_q[0];
        vrd2_d[0] = in_v ? vrd2      : vrd2_q[0];
        data_d[0] = in_v ? s1_data   : data_q[0];
        vd1_d[0]  = in_v ? s1_vd1    : vd1_q[0];
        vd2_d[0]  = in_v ? s1_vd2    : vd2_q[0];
        for (int s = 1; s < PIPE_CYCLES; s++) begin
            v_d[s]    = v_q[s-1];
            rd_d[s]   = v_q[s-1] ? rd_q[s-1]   : rd_q[s];
            vrd1_d[s] = v_q[s-1] ? vrd1_q[s-1] : vrd1_q[s];
            vrd2_d[s] = v_q[s-1] ? vrd2_q[s-1] : vrd2_q[s];
            data_d[s] = v_q[s-1] ? data_q[s-1] : data_q[s];
            vd1_d[s]  = v_q[s-1] ? vd1_q[s-1]  : vd1_q[s];
            vd2_d[s]  = v_q[s-1] ? vd2_q[s-1]  : vd2_q[s];
        end
    end

    // State registers; reset clears accumulator and discards everything in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            v_q   <= '0;
            for (int s = 0; s < PIPE_CYCLES; s++) begin
                rd_q[s]   <= '0;
                vrd1_q[s] <= '0;
                vrd2_q[s] <= '0;
                data_q[s] <= '0;
                vd1_q[s]  <= '0;
                vd2_q[s]  <= '0;
            end
        end else begin
            acc_q  <= acc_d;
            v_q    <= v_d;
            rd_q   <= rd_d;
            vrd1_q <= vrd1_d;
            vrd2_q <= vrd2_d;
            data_q <= data_d;
            vd1_q  <= vd1_d;
            vd2_q  <= vd2_d;
        end
    end

    assign out_v      = v_q[PIPE_CYCLES-1];
    assign out_rd     = rd_q[PIPE_CYCLES-1];
    assign out_vrd1   = vrd1_q[PIPE_CYCLES-1];
    assign out_vrd2   = vrd2_q[PIPE_CYCLES-1];
    assign out_data   = data_q[PIPE_CYCLES-1];
    assign out_vdata1 = vd1_q[PIPE_CYCLES-1];
    assign out_vdata2 = vd2_q[PIPE_CYCLES-1];

endmodule

// File: tb/tb_c3_simd_alu_pipe.sv
// Directed bench: three lane-width instances sharing one stimulus stream.
module tb_c3_simd_alu_pipe;
    import c3_simd_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_v;
    logic [2:0]   in_mode;
    logic [4:0]   rd;
    logic [2:0]   vrd1, vrd2;
    logic [31:0]  in_data;
    logic [255:0] in_vdata1, in_vdata2;

    logic         o32_v, o8_v, o16_v;
    logic [4:0]   o32_rd, o8_rd, o16_rd;
    logic [2:0]   o32_vrd1, o8_vrd1, o16_vrd1;
    logic [2:0]   o32_vrd2, o8_vrd2, o16_vrd2;
    logic [31:0]  o32_data, o8_data, o16_data;
    logic [255:0] o32_vd1, o8_vd1, o16_vd1;
    logic [255:0] o32_vd2, o8_vd2, o16_vd2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    c3_simd_alu_pipe #(.VLEN(256), .LANE_W(32), .PIPE_CYCLES(2)) u_dut32 (
        .clk(clk), .reset(reset), .in_v(in_v), .in_mode(in_mode), .rd(rd), .vrd1(vrd1),
        .vrd2(vrd2), .in_data(in_data), .in_vdata1(in_vdata1), .in_vdata2(in_vdata2),
        .out_v(o32_v), .out_rd(o32_rd), .out_vrd1(o32_vrd1), .out_vrd2(o32_vrd2),
        .out_data(o32_data), .out_vdata1(o32_vd1), .out_vdata2(o32_vd2)
    );

    c3_simd_alu_pipe #(.VLEN(256), .LANE_W(8), .PIPE_CYCLES(2)) u_dut8 (
        .clk(clk), .reset(reset), .in_v(in_v), .in_mode(in_mode), .rd(rd), .vrd1(vrd1),
        .vrd2(vrd2), .in_data(in_data), .in_vdata1(in_vdata1), .in_vdata2(in_vdata2),
        .out_v(o8_v), .out_rd(o8_rd), .out_vrd1(o8_vrd1), .out_vrd2(o8_vrd2),
        .out_data(o8_data), .out_vdata1(o8_vd1), .out_vdata2(o8_vd2)
    );

    c3_simd_alu_pipe #(.VLEN(256), .LANE_W(16), .PIPE_CYCLES(2)) u_dut16 (
        .clk(clk), .reset(reset), .in_v(in_v), .in_mode(in_mode), .rd(rd), .vrd1(vrd1),
        .vrd2(vrd2), .in_data(in_data), .in_vdata1(in_vdata1), .in_vdata2(in_vdata2),
        .out_v(o16_v), .out_rd(o16_rd), .out_vrd1(o16_vrd1), .out_vrd2(o16_vrd2),
        .out_data(o16_data), .out_vdata1(o16_vd1), .out_vdata2(o16_vd2)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rep32(input logic [31:0] x);
        return {8{x}};
    endfunction

    task automatic drive(input logic v, input logic [2:0] m, input logic [4:0] r,
                         input logic [31:0] d, input logic [255:0] a, input logic [255:0] b);
        in_v      = v;
        in_mode   = m;
        rd        = r;
        vrd1      = r[2:0];
        vrd2      = ~r[2:0];
        in_data   = d;
        in_vdata1 = a;
        in_vdata2 = b;
    endtask

    task automatic idle();
        in_v = 1'b0;
    endtask

    // Issues one op; returns at the negedge where its result should be on the outputs.
    task automatic run_single(input logic [2:0] m, input logic [4:0] r, input logic [31:0] d,
                              input logic [255:0] a, input logic [255:0] b);
        @(negedge clk);
        drive(1'b1, m, r, d, a, b);
        @(negedge clk);
        idle();
        check_eq("lat_early_v", {o32_v, o8_v, o16_v}, '0);
        @(negedge clk);
    endtask

    task automatic settle();
        @(negedge clk);
        check_eq("trail_v", {o32_v, o8_v, o16_v}, '0);
    endtask

    // SADDS/MINS/MAXS/SUB on LANE_W=8 with lanes {0x10,0x80,0x7F} vs {0x20,0xFF,0x01}.
    logic [2:0]   t8_mode [4] = '{C3_SADDS, C3_MINS, C3_MAXS, C3_SUB};
    logic [255:0] t8_vd1  [4] = '{256'h30807F, 256'h108001, 256'h20FF7F, 256'hF0817E};
    logic [255:0] t8_vd2  [4] = '{256'h000101, 256'h010100, 256'h000001, 256'h010100};

    // Accumulator chain on LANE_W=32: three ACC, ACCCLR, ACC, wrap, shifted product.
    logic [2:0]   ac_mode [7] = '{C3_ACC, C3_ACC, C3_ACC, C3_ACCCLR, C3_ACC, C3_ACC, C3_ACC};
    logic [31:0]  ac_a    [7] = '{3, 3, 3, 3, 3, 32'hFFFF_FFFF, 32'h10};
    logic [31:0]  ac_b    [7] = '{5, 5, 5, 5, 5, 1, 32'h10};
    logic [31:0]  ac_sh   [7] = '{0, 0, 0, 0, 0, 0, 4};
    logic [31:0]  ac_r    [7] = '{15, 30, 45, 45, 15, 14, 30};
    logic [31:0]  ac_f    [7] = '{0, 0, 0, 0, 0, 1, 0};

    initial begin
        reset = 1'b0;
        drive(1'b0, C3_ADD, 5'd0, 32'd0, '0, '0);
        repeat (3) @(negedge clk);
        check_eq("rst_v",      {o32_v, o8_v, o16_v}, '0);
        check_eq("rst_data",   {o32_data, o8_data, o16_data}, '0);
        check_eq("rst_tags",   {o32_rd, o32_vrd1, o32_vrd2}, '0);
        check_eq("rst_vd1_32", o32_vd1, '0);
        check_eq("rst_vd2_32", o32_vd2, '0);
        check_eq("rst_vd1_8",  o8_vd1, '0);
        reset = 1'b1;

        // ADD with carry out of every 32-bit lane.
        run_single(C3_ADD, 5'd5, 32'd0, '1, rep32(32'd1));
        check_eq("add_v",    o32_v, 1'b1);
        check_eq("add_vd1",  o32_vd1, '0);
        check_eq("add_vd2",  o32_vd2, rep32(32'd1));
        check_eq("add_rd",   o32_rd, 5'd5);
        check_eq("add_vrd",  {o32_vrd1, o32_vrd2}, 6'b101_010);
        check_eq("add_data", o32_data, '0);
        settle();

        for (int i = 0; i < 4; i++) begin
            run_single(t8_mode[i], 5'd3, 32'd0, 256'h10807F, 256'h20FF01);
            check_eq($sformatf("lane8_m%0d_vd1", t8_mode[i]), o8_vd1, t8_vd1[i]);
            check_eq($sformatf("lane8_m%0d_vd2", t8_mode[i]), o8_vd2, t8_vd2[i]);
            if (i == 0) begin
                check_eq("sadds32_vd1", o32_vd1, 256'h317F80);
                check_eq("sadds32_vd2", o32_vd2, '0);
            end
            settle();
        end

        // REDSUM over all-ones at three lane widths.
        run_single(C3_REDSUM, 5'd7, 32'd0, '1, '1);
        check_eq("red16_data", o16_data, 32'h000F_FFF0);
        check_eq("red16_vd1",  o16_vd1, '0);
        check_eq("red16_vd2",  o16_vd2, '0);
        check_eq("red8_data",  o8_data, 32'h0000_1FE0);
        check_eq("red32_data", o32_data, 32'hFFFF_FFF8);
        settle();

        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                check_eq($sformatf("acc%0d_v", c - 2), o32_v, 1'b1);
                check_eq($sformatf("acc%0d_r", c - 2), o32_vd1, rep32(ac_r[c-2]));
                check_eq($sformatf("acc%0d_f", c - 2), o32_vd2, rep32(ac_f[c-2]));
            end
            if (c < 7) drive(1'b1, ac_mode[c], 5'(c), ac_sh[c], rep32(ac_a[c]), rep32(ac_b[c]));
            else       idle();
        end
        settle();

        // Valid every other cycle: outputs keep the same spacing and order.
        for (int c = 0; c < 18; c++) begin
            bit exp_v;
            @(negedge clk);
            if (c >= 1) begin
                exp_v = (c >= 2) && (c % 2 == 0);
                check_eq($sformatf("gap%0d_v", c), o32_v, exp_v);
                if (exp_v) check_eq($sformatf("gap%0d_rd", c), o32_rd, 5'((c - 2) / 2 + 1));
            end
            if ((c % 2 == 0) && (c < 16)) drive(1'b1, C3_ADD, 5'(c / 2 + 1), 32'd0, '0, '0);
            else                          idle();
        end

        // Reset with two ops in flight.
        @(negedge clk);
        drive(1'b1, C3_ADD, 5'd9, 32'd0, rep32(32'd1), rep32(32'd2));
        @(negedge clk);
        drive(1'b1, C3_ADD, 5'd10, 32'd0, rep32(32'd1), rep32(32'd2));
        @(posedge clk);
        #1;
        check_eq("rst_pre_v", o32_v, 1'b1);
        reset = 1'b0;
        idle();
        #1;
        check_eq("rst_async_v",   o32_v, 1'b0);
        check_eq("rst_async_rd",  o32_rd, '0);
        check_eq("rst_async_vd1", o32_vd1, '0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("rst_ghost%0d_v", c), {o32_v, o8_v, o16_v}, '0);
        end
        run_single(C3_ACCCLR, 5'd11, 32'd0, '1, '1);
        check_eq("post_rst_v",   o32_v, 1'b1);
        check_eq("post_rst_rd",  o32_rd, 5'd11);
        check_eq("post_rst_acc", o32_vd1, '0);
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
